slice_sequencer: RTL and testbench
==================================

Name: slice_sequencer

Overview:
- Parametrised next-generation slicing controller for the cutting machine top level.
- Sequences ultrasonic ranging, carriage movement and the cut actuator until a programmed number of slices is cut.
- Adds over the first-generation controller: programmable slice thickness, echo timeout with retry, overshoot detection, pause/abort and status outputs.
- Sits between the user-input logic and the sensor, move and cut sub-controllers.

Parameters:
- NUM_W, 5: width of slice count.
- DIST_W, 12: width of distance measurement, in sensor units.
- TOL, 2: accepted |distance - target| window, in sensor units.
- MOVE_CYC, 1000: cycles move is held high per move step.
- ECHO_TO, 50000: cycles to wait for valid after triggerSuc.
- MAX_RETRY, 3: consecutive echo timeouts before error.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; honoured only in IDLE or DONE.
- pause  in  1  level; freezes sequencing while high.
- abort  in  1  one-cycle pulse; returns to IDLE from any state.
- slice_num  in  NUM_W  slices to cut; latched on start.
- target  in  DIST_W  required distance at cut position; latched on start.
- valid  in  1  one-cycle pulse: distance is fresh.
- distance  in  DIST_W  measured distance; sampled when valid=1.
- triggerSuc  in  1  sensor acknowledged trigger.
- trigger  out  1  ranging request.
- move  out  1  carriage drive enable.
- cut_end  in  1  one-cycle pulse: cut stroke finished.
- cut  out  1  cut request.
- busy  out  1  high in every state except IDLE, DONE and ERROR.
- done  out  1  one-cycle pulse on entering DONE.
- error  out  1  high in ERROR.
- slices_left  out  NUM_W  remaining slices.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. All outputs 0, slices_left=0, retry count 0, timers 0. Reset mid-cut drops cut the same edge.
- States: IDLE, TRIG, ECHO, EVAL, MOVE, CUT, DONE, ERROR. All outputs are registered.
- IDLE/DONE + start:
  - slice_num=0 -> DONE; done pulses 1 cycle after start.
  - Otherwise latch slice_num and target; slices_left=slice_num; go to TRIG.
- TRIG:
  - trigger=1 until triggerSuc is sampled high.
  - Then trigger=0 on the next cycle; clear echo timer; go to ECHO.
- ECHO:
  - valid=1 -> capture distance; clear retry count; go to EVAL.
  - Timer reaches ECHO_TO-1 without valid -> retry+1.
    - If retry reaches MAX_RETRY -> ERROR.
    - Otherwise -> TRIG.
- EVAL (1 cycle), compared at DIST_W+1 bits unsigned, no wrap:
  - distance > target+TOL -> MOVE.
  - distance < target-TOL (overshoot) -> ERROR. If target<TOL, the lower bound is treated as 0.
  - Otherwise -> CUT.
- MOVE: move=1 for exactly MOVE_CYC cycles, then move=0 and -> TRIG.
- CUT:
  - cut=1 until cut_end is sampled, then cut=0 and slices_left-1.
  - slices_left becomes 0 -> DONE with done pulse; otherwise -> TRIG.
- ERROR: error=1; stays there until abort or reset. start is ignored.
- pause=1:
  - In TRIG/ECHO/MOVE/EVAL: state and timers hold; trigger and move forced 0. On release, resume at the same point; the MOVE counter continues from its value.
  - In CUT: the stroke is not interrupted; cut stays 1 until cut_end. The transition taken after cut_end is held until pause=0. slices_left still decrements at cut_end.
- abort: highest priority after reset, above pause. Next cycle: IDLE, all outputs 0, slices_left=0.
- Simultaneous start and abort: abort wins.
- valid outside ECHO: ignored. cut_end outside CUT: ignored.

Test Plan:
- Reset and zero slices: rst_n low 2 cycles -> all outputs 0. start with slice_num=0 -> done pulses once; busy never rises.
- Three slices, target=100, TOL=2: responder returns 150, then 101, then 101 per cut. Required: one move of MOVE_CYC cycles and 3 cut handshakes; slices_left goes 3->2->1->0; done pulses once.
- Echo timeout: sensor acks but never sends valid, MAX_RETRY=3 -> 3 trigger requests, then error=1 at the 3rd timeout.
- Error recovery: from the timeout state, start is ignored; abort -> IDLE.
- Overshoot: target=100, distance=90 -> ERROR, move=0, cut=0.
- Pause: pause 200 cycles mid-MOVE -> move=0 during pause; total move-high cycles still MOVE_CYC. Pause during CUT -> cut stays high until cut_end; next trigger waits for pause release.
- Abort mid-CUT with slices_left=4 -> next cycle cut=0, slices_left=0, state IDLE.

Source files
------------

// File: rtl/slice_sequencer.sv
// Slicing controller: ranging -> evaluate -> move or cut, repeated until
// the programmed number of slices is cut. Adds echo timeout with retry,
// overshoot detection, pause, abort and status outputs.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start
// TRIG   | ranging request raised, waiting for sensor acknowledge
// ECHO   | waiting for a fresh distance, echo timer running
// EVAL   | one-cycle compare of captured distance against target window
// MOVE   | carriage driven for a fixed number of move-high cycles
// CUT    | cut stroke requested, waiting for cut_end
// DONE   | all slices cut; restartable
// ERROR  | echo retries exhausted or overshoot; left only by abort/reset

`timescale 1ns/1ps

module slice_sequencer #(
    parameter int NUM_W     = 5,
    parameter int DIST_W    = 12,
    parameter int TOL       = 2,
    parameter int MOVE_CYC  = 1000,
    parameter int ECHO_TO   = 50000,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    input  logic [NUM_W-1:0]  slice_num,
    input  logic [DIST_W-1:0] target,
    input  logic              valid,
    input  logic [DIST_W-1:0] distance,
    input  logic              triggerSuc,
    output logic              trigger,
    output logic              move,
    input  logic              cut_end,
    output logic              cut,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [NUM_W-1:0]  slices_left
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TRIG  = 3'd1;
    localparam logic [2:0] S_ECHO  = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_MOVE  = 3'd4;
    localparam logic [2:0] S_CUT   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERROR = 3'd7;

    // One shared down-counter serves both the echo timeout and the move hold.
    localparam int TMR_MAX = (MOVE_CYC > ECHO_TO) ? MOVE_CYC : ECHO_TO;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int RTY_W   = $clog2(MAX_RETRY + 1);

    localparam logic [TMR_W-1:0]  MOVE_LD = TMR_W'(MOVE_CYC);
    localparam logic [TMR_W-1:0]  ECHO_LD = TMR_W'(ECHO_TO - 1);
    localparam logic [RTY_W-1:0]  RTY_LIM = RTY_W'(MAX_RETRY);
    localparam logic [DIST_W:0]   TOL_X   = (DIST_W+1)'(TOL);

    logic [2:0]        r_state;
    logic [NUM_W-1:0]  r_slices_left;
    logic [DIST_W-1:0] r_target;
    logic [DIST_W-1:0] r_dist;
    logic [RTY_W-1:0]  r_retry;
    logic [TMR_W-1:0]  r_timer;
    logic              r_trigger;
    logic              r_move;
    logic              r_cut;
    logic              r_done;
    logic              r_error;
    logic              r_busy;

    logic [2:0]        w_state_nx;
    logic [NUM_W-1:0]  w_slices_nx;
    logic [DIST_W-1:0] w_target_nx;
    logic [DIST_W-1:0] w_dist_nx;
    logic [RTY_W-1:0]  w_retry_nx;
    logic [TMR_W-1:0]  w_timer_nx;
    logic              w_cut_nx;
    logic              w_done_nx;

    logic [DIST_W:0]   w_dist_x;
    logic [DIST_W:0]   w_hi;
    logic [DIST_W:0]   w_lo;
    logic [TMR_W-1:0]  w_move_rem;
    logic [NUM_W-1:0]  w_left_dec;
    logic [RTY_W-1:0]  w_retry_inc;

    // Window bounds are one bit wider than the distance so target+TOL
    // cannot wrap; the lower bound clamps at zero for small targets.
    assign w_dist_x    = {1'b0, r_dist};
    assign w_hi        = {1'b0, r_target} + TOL_X;
    assign w_lo        = ({1'b0, r_target} >= TOL_X) ? ({1'b0, r_target} - TOL_X) : '0;
    // A cycle counts toward the move hold only if move was actually high,
    // so a pause never eats into the programmed move time.
    assign w_move_rem  = r_timer - TMR_W'(r_move);
    assign w_left_dec  = r_slices_left - NUM_W'(1);
    assign w_retry_inc = r_retry + RTY_W'(1);

    // Next-state and datapath decisions; abort overrides everything.
    always_comb begin
        w_state_nx  = r_state;
        w_slices_nx = r_slices_left;
        w_target_nx = r_target;
        w_dist_nx   = r_dist;
        w_retry_nx  = r_retry;
        w_timer_nx  = r_timer;
        w_cut_nx    = (r_state == S_CUT) ? r_cut : 1'b0;
        w_done_nx   = 1'b0;
        if (abort) begin
            w_state_nx  = S_IDLE;
            w_slices_nx = '0;
            w_retry_nx  = '0;
            w_timer_nx  = '0;
            w_cut_nx    = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_retry_nx = '0;
                        if (slice_num == '0) begin
                            w_state_nx  = S_DONE;
                            w_done_nx   = 1'b1;
                            w_slices_nx = '0;
                        end else begin
                            w_state_nx  = S_TRIG;
                            w_slices_nx = slice_num;
                            w_target_nx = target;
                        end
                    end
                end
                S_TRIG: begin
                    if (!pause && triggerSuc) begin
                        w_state_nx = S_ECHO;
                        w_timer_nx = ECHO_LD;
                    end
                end
                S_ECHO: begin
                    if (!pause) begin
                        if (valid) begin
                            w_dist_nx  = distance;
                            w_retry_nx = '0;
                            w_state_nx = S_EVAL;
                        end else if (r_timer == '0) begin
                            w_retry_nx = w_retry_inc;
                            w_state_nx = (w_retry_inc == RTY_LIM) ? S_ERROR : S_TRIG;
                        end else begin
                            w_timer_nx = r_timer - TMR_W'(1);
                        end
                    end
                end
                S_EVAL: begin
                    if (!pause) begin
                        if (w_dist_x > w_hi) begin
                            w_state_nx = S_MOVE;
                            w_timer_nx = MOVE_LD;
                        end else if (w_dist_x < w_lo) begin
                            w_state_nx = S_ERROR;
                        end else begin
                            w_state_nx = S_CUT;
                            w_cut_nx   = 1'b1;
                        end
                    end
                end
                S_MOVE: begin
                    w_timer_nx = w_move_rem;
                    if (w_move_rem == '0) begin
                        w_state_nx = S_TRIG;
                    end
                end
                S_CUT: begin
                    // The stroke always completes; only the exit waits for pause.
                    if (r_cut) begin
                        if (cut_end) begin
                            w_cut_nx    = 1'b0;
                            w_slices_nx = w_left_dec;
                            if (!pause) begin
                                w_state_nx = (w_left_dec == '0) ? S_DONE : S_TRIG;
                                w_done_nx  = (w_left_dec == '0);
                            end
                        end
                    end else if (!pause) begin
                        w_state_nx = (r_slices_left == '0) ? S_DONE : S_TRIG;
                        w_done_nx  = (r_slices_left == '0);
                    end
                end
                S_ERROR: begin
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    // Register state, datapath and all outputs; outputs follow the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_slices_left <= '0;
            r_target      <= '0;
            r_dist        <= '0;
            r_retry       <= '0;
            r_timer       <= '0;
            r_trigger     <= 1'b0;
            r_move        <= 1'b0;
            r_cut         <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_slices_left <= w_slices_nx;
            r_target      <= w_target_nx;
            r_dist        <= w_dist_nx;
            r_retry       <= w_retry_nx;
            r_timer       <= w_timer_nx;
            r_trigger     <= (w_state_nx == S_TRIG) && !pause;
            r_move        <= (w_state_nx == S_MOVE) && !pause;
            r_cut         <= w_cut_nx;
            r_done        <= w_done_nx;
            r_error       <= (w_state_nx == S_ERROR);
            r_busy        <= (w_state_nx != S_IDLE) && (w_state_nx != S_DONE) &&
                             (w_state_nx != S_ERROR);
        end
    end

    assign trigger     = r_trigger;
    assign move        = r_move;
    assign cut         = r_cut;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign slices_left = r_slices_left;

endmodule

// File: tb/tb_slice_sequencer.sv
// Scoreboard bench for slice_sequencer: directed runs push expected output
// events; a monitor pops and compares them as the DUT produces them.

`timescale 1ns/1ps

module tb_slice_sequencer;

    localparam int NUM_W     = 5;
    localparam int DIST_W    = 12;
    localparam int TOL       = 2;
    localparam int MOVE_CYC  = 1000;
    localparam int ECHO_TO   = 40;
    localparam int MAX_RETRY = 3;

    localparam int EV_TRIG  = 1;
    localparam int EV_CUTUP = 2;
    localparam int EV_CUTDN = 3;
    localparam int EV_DONE  = 4;
    localparam int EV_ERR   = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              pause = 1'b0;
    logic              abort = 1'b0;
    logic [NUM_W-1:0]  slice_num = '0;
    logic [DIST_W-1:0] target = '0;
    logic              valid = 1'b0;
    logic [DIST_W-1:0] distance = '0;
    logic              triggerSuc = 1'b0;
    logic              cut_end = 1'b0;
    logic              trigger;
    logic              move;
    logic              cut;
    logic              busy;
    logic              done;
    logic              error;
    logic [NUM_W-1:0]  slices_left;

    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    ev_t exp_q[$];
    int  dist_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    bit  mon_en = 1'b0;
    bit  cut_en = 1'b0;
    int  kick_req = 0;
    int  ev_idx = 0;

    slice_sequencer #(
        .NUM_W(NUM_W), .DIST_W(DIST_W), .TOL(TOL),
        .MOVE_CYC(MOVE_CYC), .ECHO_TO(ECHO_TO), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
        .slice_num(slice_num), .target(target), .valid(valid), .distance(distance),
        .triggerSuc(triggerSuc), .trigger(trigger), .move(move), .cut_end(cut_end),
        .cut(cut), .busy(busy), .done(done), .error(error), .slices_left(slices_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic expect_ev(input int k, input int a, input int b);
        ev_t e;
        e.kind = k;
        e.a = a;
        e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic mon_ev(input int k, input int a, input int b);
        ev_t e;
        ev_idx++;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected event #%0d: got kind %0d a=%0d b=%0d, expected none", ev_idx, k, a, b);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("event#%0d kind", ev_idx), k, e.kind);
            chk($sformatf("event#%0d a(kind %0d)", ev_idx, e.kind), a, e.a);
            chk($sformatf("event#%0d b(kind %0d)", ev_idx, e.kind), b, e.b);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_run(input int n, input int tgt);
        @(negedge clk);
        slice_num = NUM_W'(n);
        target = DIST_W'(tgt);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    function automatic int sigv(input int which);
        case (which)
            0:       return int'(move);
            1:       return int'(cut);
            default: return int'(error);
        endcase
    endfunction

    task automatic wait_lvl(input int which, input int lvl, input int budget, input string nm);
        int n = 0;
        while (sigv(which) != lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, sigv(which), lvl);
    endtask

    task automatic drain(input int budget, input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " pending events"}, exp_q.size(), 0);
    endtask

    initial begin
        int bz;
        int bad;

        fork
            // monitor: turns output edges into events for the scoreboard
            begin
                bit p_busy = 1'b0, p_cut = 1'b0, p_trig = 1'b0, p_err = 1'b0;
                int trig_cnt = 0, move_cnt = 0;
                forever begin
                    @(negedge clk);
                    if (mon_en) begin
                        if (busy && !p_busy) begin
                            trig_cnt = 0;
                            move_cnt = 0;
                        end
                        if (move) move_cnt++;
                        if (!cut && p_cut) mon_ev(EV_CUTDN, int'(slices_left), 0);
                        if (cut && !p_cut) mon_ev(EV_CUTUP, int'(slices_left), 0);
                        if (trigger && !p_trig) begin
                            trig_cnt++;
                            mon_ev(EV_TRIG, int'(slices_left), 0);
                        end
                        if (done) mon_ev(EV_DONE, move_cnt, int'(slices_left));
                        if (error && !p_err) mon_ev(EV_ERR, trig_cnt, int'({move, cut}));
                    end
                    p_busy = busy;
                    p_cut = cut;
                    p_trig = trigger;
                    p_err = error;
                end
            end
            // sensor model: ack each trigger, answer with the next queued distance
            begin
                forever begin
                    @(negedge clk);
                    if (trigger && rst_n) begin
                        triggerSuc = 1'b1;
                        @(negedge clk);
                        triggerSuc = 1'b0;
                        if (dist_q.size() > 0) begin
                            repeat (4) @(negedge clk);
                            distance = DIST_W'(dist_q.pop_front());
                            valid = 1'b1;
                            @(negedge clk);
                            valid = 1'b0;
                        end
                    end
                end
            end
            // cutter model: auto cut_end after 3 cycles, or one on request
            begin
                int kick_done = 0;
                forever begin
                    @(negedge clk);
                    if (kick_req != kick_done) begin
                        kick_done = kick_req;
                        cut_end = 1'b1;
                        @(negedge clk);
                        cut_end = 1'b0;
                    end else if (cut_en && cut) begin
                        repeat (3) @(negedge clk);
                        cut_end = 1'b1;
                        @(negedge clk);
                        cut_end = 1'b0;
                    end
                end
            end
        join_none

        // reset
        rst_n = 1'b0;
        tick(2);
        chk("reset outputs", int'({trigger, move, cut, busy, done, error}), 0);
        chk("reset slices_left", int'(slices_left), 0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // zero slices: one done pulse, never busy
        expect_ev(EV_DONE, 0, 0);
        start_run(0, 0);
        bz = 0;
        repeat (6) begin
            bz |= int'(busy);
            @(negedge clk);
        end
        chk("zero-slice busy", bz, 0);
        drain(10, "zero");

        // three slices: 150 forces one move, then 101 per cut
        cut_en = 1'b1;
        dist_q = '{150, 101, 101, 101};
        expect_ev(EV_TRIG, 3, 0);  expect_ev(EV_TRIG, 3, 0);
        expect_ev(EV_CUTUP, 3, 0); expect_ev(EV_CUTDN, 2, 0);
        expect_ev(EV_TRIG, 2, 0);  expect_ev(EV_CUTUP, 2, 0); expect_ev(EV_CUTDN, 1, 0);
        expect_ev(EV_TRIG, 1, 0);  expect_ev(EV_CUTUP, 1, 0); expect_ev(EV_CUTDN, 0, 0);
        expect_ev(EV_DONE, MOVE_CYC, 0);
        start_run(3, 100);
        drain(3000, "three-slice");

        // window edges: 103 moves, 102 and 98 cut
        dist_q = '{103, 102, 98};
        expect_ev(EV_TRIG, 2, 0);  expect_ev(EV_TRIG, 2, 0);
        expect_ev(EV_CUTUP, 2, 0); expect_ev(EV_CUTDN, 1, 0);
        expect_ev(EV_TRIG, 1, 0);  expect_ev(EV_CUTUP, 1, 0); expect_ev(EV_CUTDN, 0, 0);
        expect_ev(EV_DONE, MOVE_CYC, 0);
        start_run(2, 100);
        drain(3000, "window-edge");

        // target below TOL: lower bound clamps to 0, distance 0 cuts
        dist_q = '{0};
        expect_ev(EV_TRIG, 1, 0); expect_ev(EV_CUTUP, 1, 0); expect_ev(EV_CUTDN, 0, 0);
        expect_ev(EV_DONE, 0, 0);
        start_run(1, 1);
        drain(500, "low-target");

        // echo timeout: three triggers, error on the third timeout
        expect_ev(EV_TRIG, 2, 0); expect_ev(EV_TRIG, 2, 0); expect_ev(EV_TRIG, 2, 0);
        expect_ev(EV_ERR, 3, 0);
        start_run(2, 100);
        drain(1000, "timeout");
        start_run(2, 100);
        tick(5);
        chk("error ignores start: error", int'(error), 1);
        chk("error ignores start: busy", int'(busy), 0);
        do_abort();
        chk("abort from error: error", int'(error), 0);
        chk("abort from error: slices_left", int'(slices_left), 0);
        chk("abort from error: busy", int'(busy), 0);

        // overshoot
        dist_q = '{90};
        expect_ev(EV_TRIG, 2, 0); expect_ev(EV_ERR, 1, 0);
        start_run(2, 100);
        drain(500, "overshoot");
        do_abort();

        // pause mid-move and mid-cut
        cut_en = 1'b0;
        dist_q = '{120, 100, 100};
        expect_ev(EV_TRIG, 2, 0);  expect_ev(EV_TRIG, 2, 0);
        expect_ev(EV_CUTUP, 2, 0); expect_ev(EV_CUTDN, 1, 0);
        expect_ev(EV_TRIG, 1, 0);  expect_ev(EV_CUTUP, 1, 0); expect_ev(EV_CUTDN, 0, 0);
        expect_ev(EV_DONE, MOVE_CYC, 0);
        start_run(2, 100);
        wait_lvl(0, 1, 200, "pause: move rises");
        tick(300);
        pause = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            bad |= int'(move);
        end
        pause = 1'b0;
        chk("pause: move low while paused", bad, 0);
        wait_lvl(1, 1, 2000, "pause: cut rises");
        pause = 1'b1;
        tick(5);
        chk("pause: cut held during stroke", int'(cut), 1);
        kick_req++;
        wait_lvl(1, 0, 10, "pause: cut drops at cut_end");
        chk("pause: slices_left after cut_end", int'(slices_left), 1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            bad |= int'(trigger);
        end
        chk("pause: no trigger while paused", bad, 0);
        cut_en = 1'b1;
        pause = 1'b0;
        drain(500, "pause");

        // abort mid-cut with four slices left
        cut_en = 1'b0;
        dist_q = '{100};
        expect_ev(EV_TRIG, 4, 0); expect_ev(EV_CUTUP, 4, 0); expect_ev(EV_CUTDN, 0, 0);
        start_run(4, 100);
        wait_lvl(1, 1, 200, "abort: cut rises");
        chk("abort: slices_left before", int'(slices_left), 4);
        do_abort();
        chk("abort: cut", int'(cut), 0);
        chk("abort: slices_left", int'(slices_left), 0);
        chk("abort: busy", int'(busy), 0);
        drain(10, "abort");

        // start and abort together: abort wins
        @(negedge clk);
        slice_num = NUM_W'(3);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start+abort: busy", int'(busy), 0);
        tick(5);

        // reset mid-cut drops cut at the reset edge
        dist_q = '{100};
        expect_ev(EV_TRIG, 3, 0); expect_ev(EV_CUTUP, 3, 0); expect_ev(EV_CUTDN, 0, 0);
        start_run(3, 100);
        wait_lvl(1, 1, 200, "reset-mid-cut: cut rises");
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset-mid-cut: cut", int'(cut), 0);
        chk("reset-mid-cut: busy", int'(busy), 0);
        rst_n = 1'b1;
        drain(10, "reset-mid-cut");
        chk("unused sensor responses", dist_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
